// File: rtl/text_buffer.sv
// Character-cell store for the text-box overlay: a 16x16 grid of 8-bit codes,
// written through a valid/ready command port and read once per pixel cycle.
module text_buffer #(
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_xy,
    input  logic [3:0]  char_line,
    output logic [10:0] font_addr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic [7:0]  cursor,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_IDLE  = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    localparam logic [1:0] OP_PUT    = 2'b00;
    localparam logic [1:0] OP_SETCUR = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [7:0] CODE_NL   = 8'h0A;

    state_e      state_q;
    logic [7:0]  clr_addr_q;
    logic [7:0]  cursor_q;
    logic        ready_q;
    logic        busy_q;
    logic [10:0] font_addr_q;
    logic [7:0]  mem_q [0:255];

    logic        accept;
    logic        we;
    logic [7:0]  waddr;
    logic [7:0]  wdata;

    assign accept = (state_q == S_IDLE) && cmd_valid && ready_q;

    // Single write port shared by the clear sweep and PUT; a cycle with rst
    // high writes nothing so an interrupted sweep stops exactly where it was.
    always_comb begin
        we    = 1'b0;
        waddr = cursor_q;
        wdata = cmd_data;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                we    = 1'b1;
                waddr = clr_addr_q;
                wdata = FILL_CHAR;
            end else if (accept && cmd_op == OP_PUT && cmd_data != CODE_NL) begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read-first: the non-blocking write lands after this read samples the array.
    always_ff @(posedge clk) begin
        if (rst) font_addr_q <= 11'd0;
        else     font_addr_q <= {mem_q[char_xy][6:0], char_line};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RST;
            clr_addr_q <= 8'd0;
            cursor_q   <= 8'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_RST: begin
                    clr_addr_q <= 8'd0;
                    if (CLEAR_ON_RESET) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_PUT: begin
                                if (cmd_data == CODE_NL)
                                    cursor_q <= {cursor_q[7:4] + 4'd1, 4'h0};
                                else
                                    cursor_q <= cursor_q + 8'd1;
                            end
                            OP_SETCUR: cursor_q <= cmd_data;
                            OP_CLEAR: begin
                                state_q    <= S_CLEAR;
                                clr_addr_q <= 8'd0;
                                busy_q     <= 1'b1;
                                ready_q    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 8'd1;
                    if (clr_addr_q == 8'hFF) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        cursor_q <= 8'd0;
                    end
                end
                default: state_q <= S_RST;
            endcase
        end
    end

    assign font_addr = font_addr_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign cursor    = cursor_q;

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: command table with expected cursors, a memory model,
// and a font_addr scoreboard fed when reads are issued.
module tb_text_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] font_addr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [7:0]  cursor;
    logic        busy;

    always #5 clk = ~clk;

    text_buffer #(.FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .char_xy(char_xy), .char_line(char_line),
        .font_addr(font_addr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cursor(cursor), .busy(busy)
    );

    localparam logic [1:0] PUT = 2'b00, SETCUR = 2'b01, CLR = 2'b10, NOP = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_cur;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem_m [256];
    logic [7:0]  cur_m;
    logic [10:0] exp_q [$];
    logic [10:0] sb_exp;
    bit          issued = 1'b0;
    vec_t        vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every cycle a read was issued, the next edge must present it.
    always @(posedge clk) begin
        if (issued) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("font_addr", {21'd0, font_addr}, {21'd0, sb_exp});
            end
        end
    end

    task automatic rd(input logic [7:0] xy, input logic [3:0] line);
        @(negedge clk);
        cmd_valid = 1'b0;
        char_xy   = xy;
        char_line = line;
        exp_q.push_back({mem_m[xy][6:0], line});
        issued = 1'b1;
    endtask

    task automatic rd_stop();
        @(negedge clk);
        issued = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain", exp_q.size(), 32'd0);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] exp_cur);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("cursor", {24'd0, cursor}, {24'd0, exp_cur});
        if (op == PUT && data != 8'h0A) mem_m[cur_m] = data;
        cur_m = exp_cur;
    endtask

    // Counts consecutive busy samples starting at the current time (just after an edge).
    task automatic count_busy(output int n, output int bad);
        n = 0;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) break;
            n++;
            if (cmd_ready) bad++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_model();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h20;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad;
        vecs[0]  = '{SETCUR, 8'h3E, 8'h3E};
        vecs[1]  = '{PUT,    8'h41, 8'h3F};
        vecs[2]  = '{PUT,    8'h42, 8'h40};
        vecs[3]  = '{SETCUR, 8'hFF, 8'hFF};
        vecs[4]  = '{PUT,    8'h31, 8'h00};
        vecs[5]  = '{SETCUR, 8'hF7, 8'hF7};
        vecs[6]  = '{PUT,    8'h0A, 8'h00};
        vecs[7]  = '{SETCUR, 8'h2F, 8'h2F};
        vecs[8]  = '{PUT,    8'h55, 8'h30};
        vecs[9]  = '{NOP,    8'h41, 8'h30};
        vecs[10] = '{PUT,    8'h0A, 8'h40};
        vecs[11] = '{PUT,    8'hC1, 8'h41};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = 8'h00;
        char_xy = 8'h00; char_line = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_font_addr", {21'd0, font_addr}, 32'd0);
        chk("rst_cursor", {24'd0, cursor}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Power-up clear
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        count_busy(n, bad);
        chk("init_busy_cycles", n, 32'd256);
        chk("init_ready_in_busy", bad, 32'd0);
        chk("init_ready", {31'd0, cmd_ready}, 32'd1);
        chk("init_cursor", {24'd0, cursor}, 32'd0);
        fill_model();
        cur_m = 8'h00;
        for (int i = 0; i < 256; i++) rd(i[7:0], i[3:0]);
        rd_stop();

        // Command table, back-to-back
        for (int i = 0; i < 12; i++) cmd(vecs[i].op, vecs[i].data, vecs[i].exp_cur);
        rd(8'h3E, 4'h5);
        rd(8'h3F, 4'h0);
        rd(8'h40, 4'h2);
        rd(8'hFF, 4'h9);
        rd(8'hF7, 4'h1);
        rd(8'h2F, 4'hF);
        rd(8'h30, 4'h0);
        rd(8'h10, 4'h7);
        rd_stop();
        chk("tc3_font_addr_const", {21'd0, mem_m[8'h3E][6:0], 4'h5}, 32'h415);

        // Read and write to the same cell in one cycle returns the old code
        cmd(SETCUR, 8'h50, 8'h50);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = PUT; cmd_data = 8'h77;
        char_xy = 8'h50; char_line = 4'hA;
        exp_q.push_back({mem_m[8'h50][6:0], 4'hA});
        issued = 1'b1;
        mem_m[8'h50] = 8'h77;
        cur_m = 8'h51;
        rd(8'h50, 4'h3);
        rd_stop();
        chk("rf_cursor", {24'd0, cursor}, 32'h51);

        // CLEAR with a PUT held pending across the sweep
        cmd(CLR, 8'h00, cur_m);
        cmd_op = PUT; cmd_data = 8'h58; cmd_valid = 1'b1;
        count_busy(n, bad);
        chk("clr_busy_cycles", n, 32'd256);
        chk("clr_ready_in_busy", bad, 32'd0);
        chk("clr_cursor_end", {24'd0, cursor}, 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("clr_put_cursor", {24'd0, cursor}, 32'h01);
        fill_model();
        mem_m[8'h00] = 8'h58;
        cur_m = 8'h01;
        rd(8'h00, 4'h4);
        rd(8'h3E, 4'h5);
        rd(8'h51, 4'h1);
        rd_stop();

        // Reset at sweep cycle 100 restarts the clear
        cmd(SETCUR, 8'hA5, 8'hA5);
        cmd(CLR, 8'h00, 8'hA5);
        cmd_valid = 1'b0;
        char_xy = 8'h00; char_line = 4'hF;
        repeat (99) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_font_addr", {21'd0, font_addr}, 32'h20F);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_font_addr", {21'd0, font_addr}, 32'd0);
        chk("mid_rst_cursor", {24'd0, cursor}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        count_busy(n, bad);
        chk("rerun_busy_cycles", n, 32'd256);
        chk("rerun_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rerun_cursor", {24'd0, cursor}, 32'd0);
        fill_model();
        cur_m = 8'h00;
        rd(8'hFF, 4'h2);
        rd(8'h64, 4'h6);
        rd(8'h00, 4'hF);
        rd_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
